// File: rtl/sha256_pkg.sv
// Shared types, constants and bit-level helper functions for the SHA-256 block engine.
package sha256_pkg;

    typedef logic [31:0]      word_t;
    typedef logic [7:0][31:0] hstate_t;   // index 0 = a / H0 ... index 7 = h / H7

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic hstate_t iv_state();
        hstate_t s;
        for (int i = 0; i < 8; i++) s[i] = IV[i];
        return s;
    endfunction

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_block_engine_round.sv
// One combinational SHA-256 round: working variables a..h, schedule word and K in,
// updated a..h out. Chained ROUNDS_PER_CYCLE deep by the engine.
module sha256_block_engine_round
    import sha256_pkg::*;
(
    input  hstate_t     i_st,
    input  logic [31:0] i_w,
    input  logic [31:0] i_k,
    output hstate_t     o_st
);

    word_t w_t1;
    word_t w_t2;

    // Compression function for a single round
    always_comb begin
        w_t1    = i_st[7] + bsig1(i_st[4]) + ch(i_st[4], i_st[5], i_st[6]) + i_k + i_w;
        w_t2    = bsig0(i_st[0]) + maj(i_st[0], i_st[1], i_st[2]);
        o_st[0] = w_t1 + w_t2;
        o_st[1] = i_st[0];
        o_st[2] = i_st[1];
        o_st[3] = i_st[2];
        o_st[4] = i_st[3] + w_t1;
        o_st[5] = i_st[4];
        o_st[6] = i_st[5];
        o_st[7] = i_st[6];
    end

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: accepts one 512-bit block per request, runs
// ROUNDS_PER_CYCLE rounds per clock and emits the chaining digest with a one-cycle strobe.
//
// state | meaning
// IDLE  | ready for a request; block and seed latched on accept
// LOAD  | a..h <= seed, round counter cleared
// ROUND | ROUNDS_PER_CYCLE chained rounds per cycle, schedule window slides
// FINAL | digest and chain register <= seed + a..h, digest strobe raised
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        first,
    input  logic [31:0] block_in [16],
    input  logic [31:0] hash_in [8],
    output logic        ready,
    output logic        busy,
    output logic        digest_valid,
    output logic [31:0] digest_out [8]
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_param
        $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam int          R    = ROUNDS_PER_CYCLE;
    localparam logic [6:0]  R_T  = 7'(ROUNDS_PER_CYCLE);

    // Window plus the R words appended this cycle
    typedef logic [15+R:0][31:0] ext_t;
    typedef logic [15:0][31:0]   win_t;

    state_t  r_state;
    logic    r_ready;
    logic    r_busy;
    logic    r_digest_valid;
    hstate_t r_digest;
    hstate_t r_chain;
    hstate_t r_seed;
    hstate_t r_st;
    win_t    r_w;
    logic [6:0] r_t;

    win_t    w_blk;
    hstate_t w_hin;
    ext_t    w_ext;
    win_t    w_w_next;
    hstate_t w_sum;
    hstate_t w_round_out;

    // Later new words may depend on earlier new words of the same cycle, so the
    // expansion is a sequential loop over an extended window.
    function automatic ext_t expand(input win_t win);
        ext_t x;
        x = '0;
        for (int i = 0; i < 16; i++) x[i] = win[i];
        for (int j = 0; j < R; j++)
            x[16+j] = x[j] + ssig0(x[j+1]) + x[j+9] + ssig1(x[j+14]);
        return x;
    endfunction

    // Port arrays to packed vectors, and the feed-forward sum for FINAL
    always_comb begin
        for (int i = 0; i < 16; i++) w_blk[i] = block_in[i];
        for (int i = 0; i < 8; i++)  w_hin[i] = hash_in[i];
        for (int i = 0; i < 8; i++)  w_sum[i] = r_seed[i] + r_st[i];
        w_ext = expand(r_w);
        for (int i = 0; i < 16; i++) w_w_next[i] = w_ext[i+R];
    end

    for (genvar j = 0; j < R; j++) begin : g_rnd
        hstate_t    w_in;
        hstate_t    w_out;
        logic [5:0] w_kidx;

        if (j == 0) begin : g_head
            assign w_in = r_st;
        end else begin : g_link
            assign w_in = g_rnd[j-1].w_out;
        end

        // Counter reaches 64 only in FINAL, where the round result is unused
        assign w_kidx = r_t[5:0] + 6'(j);

        sha256_block_engine_round u_round (
            .i_st (w_in),
            .i_w  (w_ext[j]),
            .i_k  (K[w_kidx]),
            .o_st (w_out)
        );
    end

    assign w_round_out = g_rnd[R-1].w_out;

    // Control FSM with registered handshake, strobe and digest outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_digest_valid <= 1'b0;
            r_digest       <= '0;
            r_chain        <= iv_state();
            r_seed         <= '0;
            r_st           <= '0;
            r_w            <= '0;
            r_t            <= '0;
        end else begin
            r_digest_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && r_ready) begin
                        r_w     <= w_blk;
                        r_seed  <= first ? w_hin : r_chain;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_st    <= r_seed;
                    r_t     <= '0;
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_st <= w_round_out;
                    r_w  <= w_w_next;
                    r_t  <= r_t + R_T;
                    if (r_t + R_T == 7'd64) r_state <= FINAL;
                end
                FINAL: begin
                    r_digest       <= w_sum;
                    r_chain        <= w_sum;
                    r_digest_valid <= 1'b1;
                    r_ready        <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready        = r_ready;
    assign busy         = r_busy;
    assign digest_valid = r_digest_valid;

    // Digest register out to the port array
    always_comb begin
        for (int i = 0; i < 8; i++) digest_out[i] = r_digest[i];
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine: one instance per ROUNDS_PER_CYCLE in {1,2,4,8}.
module tb_sha256_block_engine;
    import sha256_pkg::*;

    localparam int NR    = 4;
    localparam int LIMIT = 300;

    localparam logic [255:0] H_IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H_BAD = 256'hdeadbeef0123456789abcdeffeedface55aa55aa0f0f0f0f1234567887654321;
    localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_P1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_P2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_P   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start [NR];
    logic        first;
    logic [31:0] block_in [16];
    logic [31:0] hash_in [8];
    logic        ready [NR];
    logic        busy [NR];
    logic        dv [NR];
    logic [255:0] dflat [NR];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_dut
        logic [31:0] d [8];
        sha256_block_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .start        (start[g]),
            .first        (first),
            .block_in     (block_in),
            .hash_in      (hash_in),
            .ready        (ready[g]),
            .busy         (busy[g]),
            .digest_valid (dv[g]),
            .digest_out   (d)
        );
        assign dflat[g] = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
    end

    task automatic drive(input int r, input logic f, input logic [511:0] m, input logic [255:0] h);
        for (int i = 0; i < 16; i++) block_in[i] = m[511-32*i -: 32];
        for (int i = 0; i < 8; i++)  hash_in[i]  = h[255-32*i -: 32];
        first    = f;
        start[r] = 1'b1;
    endtask

    // Returns on the negedge after the accepting edge
    task automatic send(input int r, input logic f, input logic [511:0] m, input logic [255:0] h);
        @(negedge clk);
        drive(r, f, m, h);
        @(negedge clk);
        start[r] = 1'b0;
    endtask

    task automatic wait_dv(input int r, output int n);
        n = 0;
        while (dv[r] !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if ({ready[r], busy[r], dv[r], dflat[r]} !== {3'b100, 256'h0})
                $display("FAIL reset_in R=%0d got rdy=%b busy=%b dv=%b dig=%h want 1 0 0 0",
                         1 << r, ready[r], busy[r], dv[r], dflat[r]);
            else n_pass++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if ({ready[r], busy[r], dv[r], dflat[r]} !== {3'b100, 256'h0})
                $display("FAIL reset_out R=%0d got rdy=%b busy=%b dv=%b dig=%h want 1 0 0 0",
                         1 << r, ready[r], busy[r], dv[r], dflat[r]);
            else n_pass++;
        end
    endtask

    task automatic test_abc(input int r);
        int n;
        send(r, 1'b1, M_ABC, H_IV);
        wait_dv(r, n);
        n_checks++;
        if (n >= LIMIT || dflat[r] !== D_ABC)
            $display("FAIL abc R=%0d got %h (wait %0d) want %h", 1 << r, dflat[r], n, D_ABC);
        else n_pass++;
    endtask

    task automatic test_two_block(input int r);
        int n;
        send(r, 1'b1, M_P1, H_IV);
        wait_dv(r, n);
        repeat (2) @(negedge clk);
        send(r, 1'b0, M_P2, H_BAD);
        wait_dv(r, n);
        n_checks++;
        if (n >= LIMIT || dflat[r] !== D_P)
            $display("FAIL two_block R=%0d got %h (wait %0d) want %h", 1 << r, dflat[r], n, D_P);
        else n_pass++;
    endtask

    task automatic test_latency(input int r);
        int n;
        bit rdy_ok;
        send(r, 1'b1, M_ABC, H_IV);
        n = 0;
        rdy_ok = 1'b1;
        while (dv[r] !== 1'b1 && n < LIMIT) begin
            if (ready[r] !== 1'b0 || busy[r] !== 1'b1) rdy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== (64 >> r) + 2)
            $display("FAIL latency R=%0d got %0d want %0d", 1 << r, n, (64 >> r) + 2);
        else n_pass++;
        n_checks++;
        if (!rdy_ok) $display("FAIL ready_low R=%0d got ready high during block want low", 1 << r);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dv[r] !== 1'b0) $display("FAIL dv_width R=%0d got dv=%b one cycle later want 0", 1 << r, dv[r]);
        else n_pass++;
    endtask

    task automatic test_ignore_busy(input int r);
        int n;
        int pulses;
        send(r, 1'b1, M_ABC, H_IV);
        n = 0;
        pulses = 0;
        while (ready[r] !== 1'b1 && n < LIMIT) begin
            for (int i = 0; i < 16; i++) block_in[i] = $urandom;
            for (int i = 0; i < 8; i++)  hash_in[i]  = $urandom;
            first    = 1'($urandom_range(0, 1));
            start[r] = 1'b1;
            @(negedge clk);
            n++;
            if (dv[r] === 1'b1) pulses++;
        end
        start[r] = 1'b0;
        n_checks++;
        if (n >= LIMIT || dflat[r] !== D_ABC)
            $display("FAIL busy_ignore R=%0d got %h want %h", 1 << r, dflat[r], D_ABC);
        else n_pass++;
        repeat (80) begin
            @(negedge clk);
            if (dv[r] === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 1 || ready[r] !== 1'b1)
            $display("FAIL busy_queue R=%0d got pulses=%0d ready=%b want 1 1", 1 << r, pulses, ready[r]);
        else n_pass++;
    endtask

    task automatic test_reset_mid(input int r);
        int n;
        int pulses;
        send(r, 1'b1, M_ABC, H_IV);
        repeat (1 + (30 >> r)) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready[r], busy[r], dv[r], dflat[r]} !== {3'b100, 256'h0})
            $display("FAIL mid_reset R=%0d got rdy=%b busy=%b dv=%b dig=%h want 1 0 0 0",
                     1 << r, ready[r], busy[r], dv[r], dflat[r]);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (dv[r] === 1'b1 || ready[r] !== 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL mid_reset_quiet R=%0d got %0d bad cycles want 0", 1 << r, pulses);
        else n_pass++;
        send(r, 1'b0, M_ABC, H_BAD);
        wait_dv(r, n);
        n_checks++;
        if (n >= LIMIT || dflat[r] !== D_ABC)
            $display("FAIL iv_chain R=%0d got %h want %h", 1 << r, dflat[r], D_ABC);
        else n_pass++;
    endtask

    task automatic test_back_to_back(input int r);
        int n;
        int gap;
        send(r, 1'b1, M_P1, H_IV);
        wait_dv(r, n);
        n_checks++;
        if (dv[r] !== 1'b1 || ready[r] !== 1'b1)
            $display("FAIL b2b_ready R=%0d got dv=%b ready=%b want 1 1", 1 << r, dv[r], ready[r]);
        else n_pass++;
        drive(r, 1'b0, M_P2, H_BAD);
        @(negedge clk);
        start[r] = 1'b0;
        gap = 1;
        n_checks++;
        if (ready[r] !== 1'b0) $display("FAIL b2b_accept R=%0d got ready=%b want 0", 1 << r, ready[r]);
        else n_pass++;
        while (dv[r] !== 1'b1 && gap < LIMIT) begin
            @(negedge clk);
            gap++;
        end
        n_checks++;
        if (gap !== (64 >> r) + 3)
            $display("FAIL b2b_spacing R=%0d got %0d want %0d", 1 << r, gap, (64 >> r) + 3);
        else n_pass++;
        n_checks++;
        if (dflat[r] !== D_P) $display("FAIL b2b_digest R=%0d got %h want %h", 1 << r, dflat[r], D_P);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        first   = 1'b0;
        for (int r = 0; r < NR; r++) start[r] = 1'b0;
        for (int i = 0; i < 16; i++) block_in[i] = '0;
        for (int i = 0; i < 8; i++)  hash_in[i]  = '0;
        test_reset();
        for (int r = 0; r < NR; r++) begin
            test_abc(r);
            test_two_block(r);
            test_latency(r);
            test_ignore_busy(r);
            test_reset_mid(r);
            test_back_to_back(r);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
